// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 architectural register file with bypassed decode reads.
// Syscalls (print-int, print-char, exit) execute here and stall the pipeline until their output is accepted.
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
    parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall_w,
    input  logic        reg_write_w,
    input  logic        mem_to_reg_w,
    input  logic [31:0] read_data_w,
    input  logic [31:0] alu_out_w,
    input  logic [4:0]  write_reg_w,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] result_w,
    output logic        stall_wb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_kind,
    output logic [31:0] out_data,
    output logic        halted
);

    typedef enum logic [1:0] {RUN, SVC, HALT} state_t;

    state_t      state_reg, state_next;
    logic        out_valid_reg, out_valid_next;
    logic        out_kind_reg, out_kind_next;
    logic [31:0] out_data_reg, out_data_next;
    logic        halted_reg, halted_next;

    logic [31:0] regs [32];
    logic        wr_en;
    logic [31:0] v0, a0;

    assign result_w = mem_to_reg_w ? read_data_w : alu_out_w;
    assign wr_en    = reg_write_w && (write_reg_w != 5'd0) && (state_reg != HALT);

    // Syscall decode deliberately uses stored values: a syscall never sees its own write.
    assign v0 = regs[2];
    assign a0 = regs[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            regs[28] <= GP_INIT;
            regs[29] <= SP_INIT;
        end else if (wr_en) begin
            regs[write_reg_w] <= result_w;
        end
    end

    logic [4:0]  ra_port [2];
    logic [31:0] rd_port [2];

    assign ra_port[0] = ra1;
    assign ra_port[1] = ra2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            assign rd_port[gi] = (ra_port[gi] == 5'd0)                   ? 32'd0 :
                                 (wr_en && (write_reg_w == ra_port[gi])) ? result_w :
                                                                           regs[ra_port[gi]];
        end
    endgenerate

    assign rd1 = rd_port[0];
    assign rd2 = rd_port[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            out_valid_reg <= 1'b0;
            out_kind_reg  <= 1'b0;
            out_data_reg  <= 32'd0;
            halted_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            out_kind_reg  <= out_kind_next;
            out_data_reg  <= out_data_next;
            halted_reg    <= halted_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        out_kind_next  = out_kind_reg;
        out_data_next  = out_data_reg;
        halted_next    = halted_reg;
        stall_wb       = 1'b0;
        case (state_reg)
            RUN: begin
                if (syscall_w) begin
                    if (v0 == 32'd1) begin
                        state_next     = SVC;
                        out_valid_next = 1'b1;
                        out_kind_next  = 1'b0;
                        out_data_next  = a0;
                        stall_wb       = 1'b1;
                    end else if (v0 == 32'd11) begin
                        state_next     = SVC;
                        out_valid_next = 1'b1;
                        out_kind_next  = 1'b1;
                        out_data_next  = {24'd0, a0[7:0]};
                        stall_wb       = 1'b1;
                    end else if (v0 == 32'd10) begin
                        state_next  = HALT;
                        halted_next = 1'b1;
                        stall_wb    = 1'b1;
                    end
                end
            end
            SVC: begin
                // Releasing the stall in the handshake cycle lets the syscall retire exactly once.
                stall_wb = !out_ready;
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = RUN;
                end
            end
            HALT: begin
                stall_wb = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign out_valid = out_valid_reg;
    assign out_kind  = out_kind_reg;
    assign out_data  = out_data_reg;
    assign halted    = halted_reg;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus architectural register file of the 5-stage MIPS pipeline.
- Sits directly downstream of the MEM/WB pipeline register.
- Selects the writeback result and writes the 32x32 register file.
- Serves the two decode-stage read ports with write-through bypass.
- Executes syscall at WB: print-int, print-char and exit, over a valid/ready output channel, stalling the pipeline while a print is pending.

Parameters:
SP_INIT, 32'h0000_3FFC, reset value of $29 ($sp)
GP_INIT, 32'h0000_1800, reset value of $28 ($gp)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
syscall_w  in  1  syscall instruction in WB
reg_write_w  in  1  register write enable
mem_to_reg_w  in  1  1: result = read_data_w; 0: result = alu_out_w
read_data_w  in  32  data-memory read data
alu_out_w  in  32  ALU result
write_reg_w  in  5  destination register
ra1  in  5  decode read address 1
ra2  in  5  decode read address 2
rd1  out  32  read data 1
rd2  out  32  read data 2
result_w  out  32  writeback result, also used for forwarding
stall_wb  out  1  freeze the entire pipeline, including the MEM/WB register
out_valid  out  1  syscall output valid
out_ready  in  1  consumer ready
out_kind  out  1  0 = integer, 1 = character
out_data  out  32  syscall output value ($a0)
halted  out  1  exit syscall retired

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset state:
  - All registers are 0, except $28 = GP_INIT and $29 = SP_INIT.
  - FSM is in RUN; out_valid = 0, out_kind = 0, out_data = 0, halted = 0.
- rst asserted in any state, including SVC with a pending output, aborts immediately. The pending output is dropped.
- result_w: combinational, mem_to_reg_w ? read_data_w : alu_out_w.
- Register write:
  - Occurs on the rising edge of clk when reg_write_w = 1, write_reg_w != 0 and state != HALT.
  - Writes to $0 are discarded; $0 always reads 0.
- Read ports: combinational.
  - rdN = 0 if raN == 0.
  - rdN = result_w if reg_write_w = 1, write_reg_w == raN and state != HALT (bypass).
  - Otherwise rdN = the stored register value.
- Syscall decode:
  - Uses stored $2 ($v0) and $4 ($a0), without bypass.
  - A syscall with reg_write_w = 1 sees the pre-write values.
- FSM states: RUN, SVC, HALT.
- RUN:
  - syscall_w = 1 and $v0 == 1: go to SVC; out_data <= $a0, out_kind <= 0, out_valid <= 1.
  - syscall_w = 1 and $v0 == 11: same, but out_data <= {24'b0, $a0[7:0]} and out_kind <= 1.
  - syscall_w = 1 and $v0 == 10: go to HALT; halted <= 1.
  - syscall_w = 1 with any other $v0: no-op, stay in RUN.
- SVC:
  - out_valid, out_kind and out_data are held stable while out_ready = 0.
  - On a cycle with out_valid & out_ready: out_valid <= 0 and return to RUN.
  - syscall_w is ignored in SVC (no retrigger while the held instruction is presented).
- HALT: absorbing until rst. No register writes; out_valid stays 0.
- stall_wb, combinational:
  - 1 in RUN when syscall_w = 1 and $v0 is 1, 11 or 10.
  - 1 in SVC unless out_ready = 1.
  - 1 always in HALT.
  - 0 otherwise.
  - Because stall_wb falls in the handshake cycle, the pipeline advances on that edge, so the syscall retires exactly once.
- Latency:
  - out_valid rises 1 cycle after the syscall is presented.
  - Minimum syscall occupancy is 2 cycles (trigger cycle plus handshake cycle).

Test Plan:
- Reset: assert rst 1 cycle -> rd1 = 0x3FFC for ra1 = 29; rd2 = 0x1800 for ra2 = 28; rd for ra = 5 reads 0; out_valid = 0, halted = 0.
- Write/bypass: reg_write_w = 1, write_reg_w = 8, alu_out_w = 0xDEADBEEF, ra1 = 8 -> rd1 = 0xDEADBEEF in the same cycle. Next cycle, with reg_write_w = 0, rd1 still 0xDEADBEEF. mem_to_reg_w = 1 with read_data_w = 0x1234 writes 0x1234.
- $0 protection: write 0xFFFFFFFF to write_reg_w = 0 -> rd1 = 0 in the same and the following cycles.
- Print int with backpressure: $v0 = 1, $a0 = 0xFFFFFFF9, syscall_w = 1 (held while stalled), out_ready = 0 for 3 cycles then 1.
  - out_valid = 1 from cycle+1, out_data = 0xFFFFFFF9, out_kind = 0, all stable.
  - stall_wb = 1 until the handshake cycle.
  - Exactly one transfer.
- Print char: $v0 = 11, $a0 = 0x00000141, out_ready = 1 -> one transfer, out_data = 0x41, out_kind = 1; stall_wb high for 1 cycle only.
- Exit and reset recovery:
  - $v0 = 10 plus syscall -> halted = 1 and stall_wb = 1 persistently.
  - A later write to $8 is ignored.
  - rst -> RUN, halted = 0, $8 = 0.
  - rst asserted in SVC -> out_valid = 0 on the next cycle.
